// File: rtl/lfsr_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker_if
// Description : Stream/status bundle between an LFSR stream source and the
//               lfsr_checker sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_checker_if #(
    parameter int ERR_W = 16
);
    logic             clr;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             locked;
    logic             err_pulse;
    logic             lock_lost;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output clr, in_valid, in_data,
        input  locked, err_pulse, lock_lost, err_cnt
    );

    modport slave (
        input  clr, in_valid, in_data,
        output locked, err_pulse, lock_lost, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker
// Description : Hunts for, locks onto and flywheels an 8-bit Fibonacci LFSR
//               stream, counting mismatches while locked.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    lfsr_checker_if.slave bus
);
    // hunt_cnt counts the seed plus the correct predictions so far; lock is
    // declared on the match arriving while it already holds LOCK_CNT.
    localparam int HW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);

    localparam logic [HW-1:0] c_lock_cnt    = HW'(LOCK_CNT);
    localparam logic [MW-1:0] c_unlock_last = MW'(UNLOCK_CNT - 1);

    localparam logic [0:0] c_ST_HUNT   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    function automatic logic [7:0] f_nxt(input logic [7:0] s);
        return {s[6:0], s[4] ^ s[3] ^ s[2] ^ s[0]};
    endfunction

    logic [0:0]       r_state,     w_state_nxt;
    logic [7:0]       r_expected,  w_expected_nxt;
    logic [HW-1:0]    r_hunt_cnt,  w_hunt_nxt;
    logic [MW-1:0]    r_miss_cnt,  w_miss_nxt;
    logic             r_err_pulse, w_err_pulse_nxt;
    logic             r_lock_lost, w_lock_lost_nxt;
    logic [ERR_W-1:0] r_err_cnt,   w_err_cnt_nxt;
    logic             w_mismatch;
    logic             w_unlock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_HUNT;
            r_expected  <= '0;
            r_hunt_cnt  <= '0;
            r_miss_cnt  <= '0;
            r_err_pulse <= 1'b0;
            r_lock_lost <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_expected  <= w_expected_nxt;
            r_hunt_cnt  <= w_hunt_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_hunt_nxt     = r_hunt_cnt;
        w_miss_nxt     = r_miss_cnt;
        w_mismatch     = 1'b0;
        w_unlock       = 1'b0;
        if (bus.in_valid) begin
            case (r_state)
                c_ST_HUNT: begin
                    if ((r_hunt_cnt != '0) && (bus.in_data == r_expected)) begin
                        w_expected_nxt = f_nxt(bus.in_data);
                        if (r_hunt_cnt == c_lock_cnt) begin
                            w_state_nxt = c_ST_LOCKED;
                            w_hunt_nxt  = '0;
                            w_miss_nxt  = '0;
                        end else begin
                            w_hunt_nxt = r_hunt_cnt + 1'b1;
                        end
                    end else if (bus.in_data != 8'h00) begin
                        w_expected_nxt = f_nxt(bus.in_data);
                        w_hunt_nxt     = HW'(1);
                    end else begin
                        // all-zero is the LFSR lockup word, never a seed
                        w_hunt_nxt = '0;
                    end
                end
                default: begin
                    w_expected_nxt = f_nxt(r_expected);
                    if (bus.in_data == r_expected) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_mismatch = 1'b1;
                        if (r_miss_cnt == c_unlock_last) begin
                            w_unlock    = 1'b1;
                            w_state_nxt = c_ST_HUNT;
                            w_hunt_nxt  = '0;
                            w_miss_nxt  = '0;
                        end else begin
                            w_miss_nxt = r_miss_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_err_pulse_nxt = w_mismatch;
        w_lock_lost_nxt = w_unlock;
        w_err_cnt_nxt   = r_err_cnt;
        if (bus.clr) begin
            w_err_cnt_nxt = '0;
        end else if (w_mismatch && (r_err_cnt != '1)) begin
            w_err_cnt_nxt = r_err_cnt + 1'b1;
        end
    end

    assign bus.locked    = (r_state == c_ST_LOCKED);
    assign bus.err_pulse = r_err_pulse;
    assign bus.lock_lost = r_lock_lost;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_checker
// Description : Directed self-checking bench for lfsr_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;
    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       clr      = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    int         total    = 0;
    int         bad      = 0;

    logic [7:0] seq [0:4] = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C};

    always #5 clk = ~clk;

    lfsr_checker_if #(.ERR_W(16)) if_a ();
    lfsr_checker_if #(.ERR_W(2))  if_b ();

    assign if_a.clr      = clr;
    assign if_a.in_valid = in_valid;
    assign if_a.in_data  = in_data;
    assign if_b.clr      = clr;
    assign if_b.in_valid = in_valid;
    assign if_b.in_data  = in_data;

    lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(8), .ERR_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    task automatic send(input logic [7:0] d, input logic c);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic c);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'hA5;
            clr      = c;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        clr      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total++; if (if_a.locked !== 1'b0) begin bad++; $display("FAIL reset locked got=%b want=0", if_a.locked); end
        total++; if (if_a.err_pulse !== 1'b0) begin bad++; $display("FAIL reset err_pulse got=%b want=0", if_a.err_pulse); end
        total++; if (if_a.lock_lost !== 1'b0) begin bad++; $display("FAIL reset lock_lost got=%b want=0", if_a.lock_lost); end
        total++; if (if_a.err_cnt !== 16'd0) begin bad++; $display("FAIL reset err_cnt got=%0d want=0", if_a.err_cnt); end
        total++; if (if_b.err_cnt !== 2'd0) begin bad++; $display("FAIL reset err_cnt_b got=%0d want=0", if_b.err_cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lockup;
        for (int i = 0; i < 5; i++) begin
            send(seq[i], 1'b0);
            total++;
            if (if_a.locked !== (i == 4)) begin
                bad++; $display("FAIL lockup locked[%0d] got=%b want=%b", i, if_a.locked, (i == 4));
            end
        end
        total++; if (if_a.err_cnt !== 16'd0) begin bad++; $display("FAIL lockup err_cnt got=%0d want=0", if_a.err_cnt); end
    endtask

    task automatic test_single_error;
        send(8'h39, 1'b0);
        total++; if (if_a.err_pulse !== 1'b0) begin bad++; $display("FAIL single good pulse got=%b want=0", if_a.err_pulse); end
        send(8'h72, 1'b0);
        total++; if (if_a.err_pulse !== 1'b1) begin bad++; $display("FAIL single err_pulse got=%b want=1", if_a.err_pulse); end
        total++; if (if_a.err_cnt !== 16'd1) begin bad++; $display("FAIL single err_cnt got=%0d want=1", if_a.err_cnt); end
        total++; if (if_a.locked !== 1'b1) begin bad++; $display("FAIL single locked got=%b want=1", if_a.locked); end
        send(8'hE6, 1'b0);
        total++; if (if_a.err_pulse !== 1'b0) begin bad++; $display("FAIL single after pulse got=%b want=0", if_a.err_pulse); end
        total++; if (if_a.err_cnt !== 16'd1) begin bad++; $display("FAIL single after cnt got=%0d want=1", if_a.err_cnt); end
    endtask

    task automatic test_loss_of_lock;
        idle(1, 1'b1);
        total++; if (if_a.err_cnt !== 16'd0) begin bad++; $display("FAIL clr err_cnt got=%0d want=0", if_a.err_cnt); end
        total++; if (if_a.locked !== 1'b1) begin bad++; $display("FAIL clr locked got=%b want=1", if_a.locked); end
        send(8'hFF, 1'b0);
        total++; if (if_a.err_cnt !== 16'd1) begin bad++; $display("FAIL loss cnt1 got=%0d want=1", if_a.err_cnt); end
        total++; if (if_a.lock_lost !== 1'b0) begin bad++; $display("FAIL loss early lock_lost got=%b want=0", if_a.lock_lost); end
        send(8'hFF, 1'b0);
        total++; if (if_a.err_cnt !== 16'd2) begin bad++; $display("FAIL loss cnt2 got=%0d want=2", if_a.err_cnt); end
        total++; if (if_a.locked !== 1'b1) begin bad++; $display("FAIL loss locked2 got=%b want=1", if_a.locked); end
        send(8'hFF, 1'b1);
        total++; if (if_a.err_cnt !== 16'd0) begin bad++; $display("FAIL loss clr cnt got=%0d want=0", if_a.err_cnt); end
        total++; if (if_a.lock_lost !== 1'b1) begin bad++; $display("FAIL loss lock_lost got=%b want=1", if_a.lock_lost); end
        total++; if (if_a.locked !== 1'b0) begin bad++; $display("FAIL loss locked got=%b want=0", if_a.locked); end
        total++; if (if_a.err_pulse !== 1'b1) begin bad++; $display("FAIL loss err_pulse got=%b want=1", if_a.err_pulse); end
        idle(1, 1'b0);
        total++; if (if_a.lock_lost !== 1'b0) begin bad++; $display("FAIL loss pulse drop got=%b want=0", if_a.lock_lost); end
        total++; if (if_a.err_pulse !== 1'b0) begin bad++; $display("FAIL loss err drop got=%b want=0", if_a.err_pulse); end
        for (int i = 0; i < 5; i++) begin
            send(seq[i], 1'b0);
            total++;
            if (if_a.locked !== (i == 4)) begin
                bad++; $display("FAIL relock locked[%0d] got=%b want=%b", i, if_a.locked, (i == 4));
            end
        end
    endtask

    task automatic test_zero_and_gaps;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(8'h00, 1'b0);
            total++; if (if_a.locked !== 1'b0) begin bad++; $display("FAIL zero locked[%0d] got=%b want=0", i, if_a.locked); end
        end
        for (int i = 0; i < 5; i++) begin
            send(seq[i], 1'b0);
            total++;
            if (if_a.locked !== (i == 4)) begin
                bad++; $display("FAIL gaps locked[%0d] got=%b want=%b", i, if_a.locked, (i == 4));
            end
            if (i < 4) idle(5, 1'b0);
        end
        idle(3, 1'b0);
        send(8'h39, 1'b0);
        total++; if (if_a.err_pulse !== 1'b0) begin bad++; $display("FAIL gaps flywheel pulse got=%b want=0", if_a.err_pulse); end
        total++; if (if_a.err_cnt !== 16'd0) begin bad++; $display("FAIL gaps err_cnt got=%0d want=0", if_a.err_cnt); end
    endtask

    task automatic test_saturation;
        logic [1:0] want;
        do_reset();
        for (int i = 0; i < 5; i++) send(seq[i], 1'b0);
        total++; if (if_b.locked !== 1'b1) begin bad++; $display("FAIL sat lock got=%b want=1", if_b.locked); end
        for (int i = 0; i < 5; i++) begin
            send(8'hFF, 1'b0);
            want = (i < 3) ? 2'(i + 1) : 2'd3;
            total++; if (if_b.err_cnt !== want) begin bad++; $display("FAIL sat err_cnt[%0d] got=%0d want=%0d", i, if_b.err_cnt, want); end
            total++; if (if_b.err_pulse !== 1'b1) begin bad++; $display("FAIL sat pulse[%0d] got=%b want=1", i, if_b.err_pulse); end
        end
        total++; if (if_b.locked !== 1'b1) begin bad++; $display("FAIL sat still locked got=%b want=1", if_b.locked); end
        send(8'hFF, 1'b1);
        total++; if (if_b.err_cnt !== 2'd0) begin bad++; $display("FAIL sat clr cnt got=%0d want=0", if_b.err_cnt); end
        total++; if (if_b.err_pulse !== 1'b1) begin bad++; $display("FAIL sat clr pulse got=%b want=1", if_b.err_pulse); end
    endtask

    task automatic test_async_reset;
        do_reset();
        for (int i = 0; i < 5; i++) send(seq[i], 1'b0);
        send(8'h00, 1'b0);
        total++; if (if_a.err_cnt !== 16'd1) begin bad++; $display("FAIL arst pre cnt got=%0d want=1", if_a.err_cnt); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (if_a.locked !== 1'b0) begin bad++; $display("FAIL arst locked got=%b want=0", if_a.locked); end
        total++; if (if_a.err_cnt !== 16'd0) begin bad++; $display("FAIL arst err_cnt got=%0d want=0", if_a.err_cnt); end
        total++; if (if_a.err_pulse !== 1'b0) begin bad++; $display("FAIL arst err_pulse got=%b want=0", if_a.err_pulse); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(seq[i], 1'b0);
            total++;
            if (if_a.locked !== (i == 4)) begin
                bad++; $display("FAIL arst relock[%0d] got=%b want=%b", i, if_a.locked, (i == 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_lockup();
        test_single_error();
        test_loss_of_lock();
        test_zero_and_gaps();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
